axi3_apb_bridge: RTL and testbench

- AXI3 slave to APB (AMBA 3, with PREADY/PSLVERR) master bridge. It sits downstream of the AXI interconnect/master and upstream of APB slaves.
- Converts each AXI burst beat into one APB transfer and returns B/R responses.
- Handles one transaction at a time. Reads and writes are arbitrated round-robin.

---
 rtl/axi3_apb_bridge_pkg.sv | 35 +++
 rtl/axi3_burst_addr_gen.sv | 55 +++++
 rtl/axi3_apb_bridge.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi3_apb_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_apb_bridge_pkg.sv
// Shared types for the AXI3-to-APB bridge: burst/response encodings, bridge
// states and the WRAP length legality helper.
package axi3_apb_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_BRESP,
    ST_RDATA
  } bridge_state_t;

  // Largest AxSIZE a 32-bit data path can carry (4 bytes).
  localparam logic [2:0] MAX_SIZE = 3'd2;

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi3_burst_addr_gen.sv
// Per-beat address and beat counter for one AXI3 burst; computes the next
// beat address for FIXED/INCR/WRAP and flags the final beat.
module axi3_burst_addr_gen
  import axi3_apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  advance,
  input  logic [3:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [3:0]            beat,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;

  // WRAP keeps the bits above the (len+1)*bytes container and wraps the rest.
  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size;
    incr_addr = addr + bytes;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr = incr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      beat <= '0;
    end else if (load) begin
      addr <= load_addr;
      beat <= '0;
    end else if (advance) begin
      addr <= next_addr;
      beat <= beat + 4'd1;
    end
  end

  assign last = (beat == len);

endmodule

// File: rtl/axi3_apb_bridge.sv
// AXI3 slave to APB master bridge: one transaction at a time, each burst beat
// becomes one APB transfer; all AXI and APB outputs are registered.
module axi3_apb_bridge
  import axi3_apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  bridge_state_t         state;
  logic                  read_pref;
  logic [ID_WIDTH-1:0]   id_q;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  is_write;
  logic                  size_bad;
  logic                  err;
  logic                  pick_read;
  logic                  pick_write;
  logic                  gen_load;
  logic                  gen_advance;
  logic [ADDR_WIDTH-1:0] gen_load_addr;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [3:0]            gen_beat;
  logic                  gen_last;
  logic                  unused_inputs;

  assign unused_inputs = ^{wid, wstrb, wlast};

  assign pick_read  = arvalid && (!awvalid || read_pref);
  assign pick_write = awvalid && !pick_read;

  // A beat completes at the end of ACCESS, or at the AXI handshake when an
  // oversized beat skips the APB side altogether.
  always_comb begin
    gen_load      = (state == ST_IDLE) && (awvalid || arvalid);
    gen_load_addr = pick_read ? araddr : awaddr;
    gen_advance   = ((state == ST_ACCESS) && pready) ||
                    ((state == ST_WDATA) && size_bad && wvalid && wready) ||
                    ((state == ST_RDATA) && size_bad && rready);
  end

  axi3_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk       (aclk),
    .rst_n     (areset_n),
    .load      (gen_load),
    .load_addr (gen_load_addr),
    .advance   (gen_advance),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .addr      (gen_addr),
    .beat      (gen_beat),
    .last      (gen_last)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= ST_IDLE;
      read_pref <= 1'b1;
      id_q      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      is_write  <= 1'b0;
      size_bad  <= 1'b0;
      err       <= 1'b0;
      awready   <= 1'b0;
      arready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
      rvalid    <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= '0;
      rlast     <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      awready <= 1'b0;
      arready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (awvalid && arvalid) read_pref <= !read_pref;
          if (pick_read) begin
            arready  <= 1'b1;
            id_q     <= arid;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= arburst;
            is_write <= 1'b0;
            size_bad <= (arsize > MAX_SIZE);
            err      <= (arsize > MAX_SIZE);
            if (arsize > MAX_SIZE) begin
              rvalid <= 1'b1;
              rid    <= arid;
              rdata  <= '0;
              rresp  <= RESP_SLVERR;
              rlast  <= (arlen == 4'd0);
              state  <= ST_RDATA;
            end else begin
              psel    <= 1'b1;
              penable <= 1'b0;
              pwrite  <= 1'b0;
              paddr   <= araddr;
              state   <= ST_SETUP;
            end
          end else if (pick_write) begin
            awready  <= 1'b1;
            id_q     <= awid;
            len_q    <= awlen;
            size_q   <= awsize;
            burst_q  <= awburst;
            is_write <= 1'b1;
            size_bad <= (awsize > MAX_SIZE);
            err      <= (awsize > MAX_SIZE);
            wready   <= 1'b1;
            state    <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (wvalid && wready) begin
            if (size_bad) begin
              if (gen_last) begin
                wready <= 1'b0;
                bvalid <= 1'b1;
                bid    <= id_q;
                bresp  <= RESP_SLVERR;
                state  <= ST_BRESP;
              end
            end else begin
              wready  <= 1'b0;
              pwdata  <= wdata;
              psel    <= 1'b1;
              penable <= 1'b0;
              pwrite  <= 1'b1;
              paddr   <= gen_addr;
              state   <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (is_write) begin
              err <= err || pslverr;
              if (gen_last) begin
                bvalid <= 1'b1;
                bid    <= id_q;
                bresp  <= (err || pslverr) ? RESP_SLVERR : RESP_OKAY;
                state  <= ST_BRESP;
              end else begin
                wready <= 1'b1;
                state  <= ST_WDATA;
              end
            end else begin
              rvalid <= 1'b1;
              rid    <= id_q;
              rdata  <= prdata;
              rresp  <= pslverr ? RESP_SLVERR : RESP_OKAY;
              rlast  <= gen_last;
              state  <= ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              rresp  <= RESP_OKAY;
              state  <= ST_IDLE;
            end else if (size_bad) begin
              rlast <= ((gen_beat + 4'd1) == len_q);
            end else begin
              rvalid  <= 1'b0;
              psel    <= 1'b1;
              penable <= 1'b0;
              pwrite  <= 1'b0;
              paddr   <= gen_addr;
              state   <= ST_SETUP;
            end
          end
        end
        ST_BRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi3_apb_bridge.sv
// Scoreboard bench for axi3_apb_bridge: APB slave model, R/B monitors and
// expected-result queues filled as each AXI transaction is issued.
module tb_axi3_apb_bridge;
  import axi3_apb_bridge_pkg::*;

  localparam int TMO = 400;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [3:0]  awid, arid, wid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata, paddr, pwdata, prdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        psel, penable, pwrite, pready, pslverr;

  typedef struct packed {logic [31:0] addr; logic wr; logic [31:0] data;} apb_exp_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last;} r_exp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;

  apb_exp_t    apb_q[$];
  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  int          total = 0;
  int          bad = 0;
  int          apb_count = 0;
  int          err_at = -1;
  int          wait_n = 0;
  bit          stall_en = 1'b0;
  logic [31:0] wr_data[16];

  always #5 aclk = ~aclk;

  axi3_apb_bridge dut (
    .aclk(aclk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expApb(input logic [31:0] a, input logic wr, input logic [31:0] d);
    apb_q.push_back('{addr: a, wr: wr, data: d});
  endtask

  task automatic expR(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id, input logic last);
    r_q.push_back('{data: d, resp: resp, id: id, last: last});
  endtask

  task automatic expB(input logic [3:0] id, input logic [1:0] resp);
    b_q.push_back('{id: id, resp: resp});
  endtask

  // APB slave: wait_n wait states per transfer, pslverr on transfer err_at.
  initial begin : apb_slave
    int wait_cnt;
    bit setup_seen;
    apb_exp_t e;
    wait_cnt = 0;
    setup_seen = 0;
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = '0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        pready = 1'b0;
        pslverr = 1'b0;
        wait_cnt = 0;
        setup_seen = 0;
      end else if (psel && !penable) begin
        setup_seen = 1;
        pready = 1'b0;
        pslverr = 1'b0;
      end else if (psel && penable) begin
        if (wait_cnt >= wait_n) begin
          pready = 1'b1;
          pslverr = (apb_count == err_at);
          prdata = rd_model(paddr);
          checkOutput("apb_setup_phase", setup_seen, 1);
          checkOutput("apb_expected", apb_q.size() != 0, 1);
          if (apb_q.size() != 0) begin
            e = apb_q.pop_front();
            checkOutput("apb_addr", paddr, e.addr);
            checkOutput("apb_write", pwrite, e.wr);
            if (e.wr) checkOutput("apb_wdata", pwdata, e.data);
          end
          apb_count++;
          wait_cnt = 0;
          setup_seen = 0;
        end else begin
          pready = 1'b0;
          wait_cnt++;
        end
      end else begin
        pready = 1'b0;
        pslverr = 1'b0;
      end
    end
  end

  // R/B monitor: drives ready (randomly stalled when stall_en) and scores beats.
  initial begin : resp_mon
    bit hold;
    logic [38:0] held;
    r_exp_t re;
    b_exp_t be;
    hold = 0;
    held = '0;
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        hold = 0;
        rready = 1'b0;
        bready = 1'b0;
      end else begin
        if (hold) begin
          checkOutput("r_hold_valid", rvalid, 1);
          checkOutput("r_hold_bits", {rid, rdata, rresp, rlast}, held);
        end
        rready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rvalid && rready) begin
          checkOutput("r_expected", r_q.size() != 0, 1);
          if (r_q.size() != 0) begin
            re = r_q.pop_front();
            checkOutput("r_data", rdata, re.data);
            checkOutput("r_resp", rresp, re.resp);
            checkOutput("r_id", rid, re.id);
            checkOutput("r_last", rlast, re.last);
          end
        end
        hold = rvalid && !rready;
        held = {rid, rdata, rresp, rlast};
        if (bvalid && bready) begin
          checkOutput("b_expected", b_q.size() != 0, 1);
          if (b_q.size() != 0) begin
            be = b_q.pop_front();
            checkOutput("b_id", bid, be.id);
            checkOutput("b_resp", bresp, be.resp);
          end
        end
      end
    end
  end

  task automatic sendAw(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge aclk);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < TMO) begin @(negedge aclk); n++; end
    checkOutput("aw_handshake", awready, 1);
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic sendAr(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge aclk);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < TMO) begin @(negedge aclk); n++; end
    checkOutput("ar_handshake", arready, 1);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic sendW(input logic [3:0] id, input logic [3:0] len);
    int n;
    @(negedge aclk);
    for (int b = 0; b <= int'(len); b++) begin
      wid = id; wdata = wr_data[b]; wstrb = 4'hF; wlast = (b == int'(len)); wvalid = 1'b1;
      n = 0;
      while (!wready && n < TMO) begin @(negedge aclk); n++; end
      checkOutput("w_handshake", wready, 1);
      @(posedge aclk);
      @(negedge aclk);
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic applyStimulus(input bit is_write, input logic [3:0] id, input logic [31:0] a,
                               input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (is_write) begin
      fork
        sendAw(id, a, len, size, burst);
        sendW(id, len);
      join
    end else begin
      sendAr(id, a, len, size, burst);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((apb_q.size() + r_q.size() + b_q.size()) != 0 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("drain", apb_q.size() + r_q.size() + b_q.size(), 0);
    repeat (3) @(negedge aclk);
  endtask

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int base, n;
    areset_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    repeat (3) @(negedge aclk);
    checkOutput("rst_awready", awready, 0);
    checkOutput("rst_arready", arready, 0);
    checkOutput("rst_wready", wready, 0);
    checkOutput("rst_bvalid", bvalid, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_psel_penable", {psel, penable, pwrite}, 0);
    checkOutput("rst_paddr", paddr, 0);
    checkOutput("rst_resp", {bresp, rresp}, 0);
    areset_n = 1'b1;
    repeat (2) @(negedge aclk);

    $display("[TB] arbitration: first simultaneous pair, read expected first");
    wr_data[0] = 32'h1111_1111;
    expApb(32'h500, 1'b0, '0);
    expR(rd_model(32'h500), RESP_OKAY, 4'd2, 1'b1);
    expApb(32'h400, 1'b1, 32'h1111_1111);
    expB(4'd1, RESP_OKAY);
    fork
      applyStimulus(1'b0, 4'd2, 32'h500, 4'd0, 3'd2, BURST_INCR);
      applyStimulus(1'b1, 4'd1, 32'h400, 4'd0, 3'd2, BURST_INCR);
    join
    waitDrain();

    $display("[TB] arbitration: second simultaneous pair, write expected first");
    wr_data[0] = 32'h2222_2222;
    expApb(32'h404, 1'b1, 32'h2222_2222);
    expB(4'd3, RESP_OKAY);
    expApb(32'h504, 1'b0, '0);
    expR(rd_model(32'h504), RESP_OKAY, 4'd4, 1'b1);
    fork
      applyStimulus(1'b0, 4'd4, 32'h504, 4'd0, 3'd2, BURST_INCR);
      applyStimulus(1'b1, 4'd3, 32'h404, 4'd0, 3'd2, BURST_INCR);
    join
    waitDrain();

    $display("[TB] single write");
    wr_data[0] = 32'hDEAD_BEEF;
    expApb(32'h100, 1'b1, 32'hDEAD_BEEF);
    expB(4'd3, RESP_OKAY);
    applyStimulus(1'b1, 4'd3, 32'h100, 4'd0, 3'd2, BURST_INCR);
    waitDrain();

    $display("[TB] INCR read, wait states and R backpressure");
    wait_n = 2;
    stall_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expApb(32'h200 + 32'(4 * i), 1'b0, '0);
      expR(rd_model(32'h200 + 32'(4 * i)), RESP_OKAY, 4'd5, i == 3);
    end
    applyStimulus(1'b0, 4'd5, 32'h200, 4'd3, 3'd2, BURST_INCR);
    waitDrain();
    stall_en = 1'b0;
    wait_n = 0;

    $display("[TB] WRAP read");
    expApb(32'h38, 1'b0, '0); expR(rd_model(32'h38), RESP_OKAY, 4'd7, 1'b0);
    expApb(32'h3C, 1'b0, '0); expR(rd_model(32'h3C), RESP_OKAY, 4'd7, 1'b0);
    expApb(32'h30, 1'b0, '0); expR(rd_model(32'h30), RESP_OKAY, 4'd7, 1'b0);
    expApb(32'h34, 1'b0, '0); expR(rd_model(32'h34), RESP_OKAY, 4'd7, 1'b1);
    applyStimulus(1'b0, 4'd7, 32'h38, 4'd3, 3'd2, BURST_WRAP);
    waitDrain();

    $display("[TB] write burst with slave error on first beat");
    err_at = apb_count;
    wr_data[0] = 32'hAAAA_0001;
    wr_data[1] = 32'hBBBB_0002;
    expApb(32'h300, 1'b1, 32'hAAAA_0001);
    expApb(32'h304, 1'b1, 32'hBBBB_0002);
    expB(4'd4, RESP_SLVERR);
    applyStimulus(1'b1, 4'd4, 32'h300, 4'd1, 3'd2, BURST_INCR);
    waitDrain();
    err_at = -1;

    $display("[TB] oversized read and write");
    expR('0, RESP_SLVERR, 4'd8, 1'b0);
    expR('0, RESP_SLVERR, 4'd8, 1'b1);
    applyStimulus(1'b0, 4'd8, 32'h800, 4'd1, 3'd3, BURST_INCR);
    waitDrain();
    wr_data[0] = 32'h1234_5678;
    expB(4'd9, RESP_SLVERR);
    applyStimulus(1'b1, 4'd9, 32'h900, 4'd0, 3'd3, BURST_INCR);
    waitDrain();

    $display("[TB] reset during third beat of a read burst");
    wait_n = 3;
    base = apb_count;
    for (int i = 0; i < 4; i++) begin
      expApb(32'h600 + 32'(4 * i), 1'b0, '0);
      expR(rd_model(32'h600 + 32'(4 * i)), RESP_OKAY, 4'd6, i == 3);
    end
    applyStimulus(1'b0, 4'd6, 32'h600, 4'd3, 3'd2, BURST_INCR);
    n = 0;
    while (!(apb_count == base + 2 && psel && penable) && n < TMO) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("reach_beat2_access", {psel, penable}, 2'b11);
    #2;
    areset_n = 1'b0;
    #1;
    checkOutput("midrst_psel", psel, 0);
    checkOutput("midrst_penable", penable, 0);
    checkOutput("midrst_rvalid", rvalid, 0);
    apb_q.delete();
    r_q.delete();
    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    wait_n = 0;
    @(negedge aclk);
    checkOutput("post_rst_quiet", {arready, rvalid, bvalid, psel}, 0);
    expApb(32'h700, 1'b0, '0);
    expR(rd_model(32'h700), RESP_OKAY, 4'd10, 1'b1);
    applyStimulus(1'b0, 4'd10, 32'h700, 4'd0, 3'd2, BURST_INCR);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
